// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo family: occupancy arithmetic and parameter legality.
package sync_fifo_pkg;

  // Occupancy from (PtrWidth+1)-bit pointers, modulo 2^(PtrWidth+1).
  function automatic int unsigned fifo_count(input int unsigned wr_ptr,
                                             input int unsigned rd_ptr,
                                             input int unsigned ptr_width);
    int unsigned mask;
    mask = (32'd1 << (ptr_width + 1)) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned ptr_width,
                                      input int unsigned af_thr,
                                      input int unsigned ae_thr,
                                      input int unsigned fwft);
    return is_pow2(depth) && ((32'd1 << ptr_width) == depth) &&
           (af_thr >= 1) && (af_thr <= depth) &&
           (ae_thr <= depth - 1) && (fwft <= 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ext_if.sv
// Producer/consumer bundle for sync_fifo_ext; master is the user side, slave the FIFO.
interface sync_fifo_ext_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned PtrWidth  = 3
) ();
  logic                 wr_en;
  logic [DataWidth-1:0] wr_data;
  logic                 rd_en;
  logic [DataWidth-1:0] rd_data;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [PtrWidth:0]    count;
  logic                 err_clr;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ptr.sv
// Pointer registers, accept logic, occupancy, level flags and sticky error flags.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int unsigned Depth          = 8,
  parameter int unsigned PtrWidth       = 3,
  parameter int unsigned AlmostFullThr  = 6,
  parameter int unsigned AlmostEmptyThr = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic                err_clr,
  output logic                wr_acc,
  output logic                rd_acc,
  output logic [PtrWidth-1:0] wr_addr,
  output logic [PtrWidth-1:0] rd_addr,
  output logic [PtrWidth:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);
  localparam int unsigned CW = PtrWidth + 1;

  logic [PtrWidth:0] wr_ptr;
  logic [PtrWidth:0] rd_ptr;

  assign wr_addr = wr_ptr[PtrWidth-1:0];
  assign rd_addr = rd_ptr[PtrWidth-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]) &&
                 (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]);
  assign count = CW'(fifo_count(32'(wr_ptr), 32'(rd_ptr), PtrWidth));

  assign almost_full  = (32'(count) >= AlmostFullThr);
  assign almost_empty = (32'(count) <= AlmostEmptyThr);

  // A pop in the same cycle frees the slot a write on a full FIFO needs.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      // Set beats clear when both happen in one cycle.
      if (wr_en && !wr_acc)  overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd_en && !rd_acc)  underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end
endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with thresholds, occupancy, sticky errors and optional FWFT read.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned Depth          = 8,
  parameter int unsigned PtrWidth       = $clog2(Depth),
  parameter int unsigned AlmostFullThr  = Depth - 2,
  parameter int unsigned AlmostEmptyThr = 1,
  parameter int unsigned Fwft           = 0
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_ext_if.slave fifo
);
  if (!params_legal(Depth, PtrWidth, AlmostFullThr, AlmostEmptyThr, Fwft)) begin : g_bad_params
    $error("sync_fifo_ext: illegal parameter combination");
  end

  logic [DataWidth-1:0] mem [Depth];
  logic                 wr_acc;
  logic                 rd_acc;
  logic [PtrWidth-1:0]  wr_addr;
  logic [PtrWidth-1:0]  rd_addr;
  logic [DataWidth-1:0] rd_data;

  sync_fifo_ptr #(
    .Depth         (Depth),
    .PtrWidth      (PtrWidth),
    .AlmostFullThr (AlmostFullThr),
    .AlmostEmptyThr(AlmostEmptyThr)
  ) u_ptr (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (fifo.wr_en),
    .rd_en       (fifo.rd_en),
    .err_clr     (fifo.err_clr),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .count       (fifo.count),
    .full        (fifo.full),
    .empty       (fifo.empty),
    .almost_full (fifo.almost_full),
    .almost_empty(fifo.almost_empty),
    .overflow    (fifo.overflow),
    .underflow   (fifo.underflow)
  );

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_addr] <= fifo.wr_data;
  end

  if (Fwft != 0) begin : g_fwft
    assign rd_data = mem[rd_addr];
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (rst)         rd_data <= '0;
      else if (rd_acc) rd_data <= mem[rd_addr];
    end
  end

  assign fifo.rd_data = rd_data;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: registered-read and FWFT instances side by side.
module tb_sync_fifo_ext;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_ext_if #(.DataWidth(32), .PtrWidth(3)) if_r ();
  sync_fifo_ext_if #(.DataWidth(32), .PtrWidth(3)) if_f ();

  sync_fifo_ext #(
    .DataWidth(32), .Depth(8), .PtrWidth(3),
    .AlmostFullThr(6), .AlmostEmptyThr(1), .Fwft(0)
  ) u_reg (.clk(clk), .rst(rst), .fifo(if_r.slave));

  sync_fifo_ext #(
    .DataWidth(32), .Depth(8), .PtrWidth(3),
    .AlmostFullThr(6), .AlmostEmptyThr(1), .Fwft(1)
  ) u_fwft (.clk(clk), .rst(rst), .fifo(if_f.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_r.wr_en = 1'b0; if_r.rd_en = 1'b0; if_r.err_clr = 1'b0; if_r.wr_data = '0;
    if_f.wr_en = 1'b0; if_f.rd_en = 1'b0; if_f.err_clr = 1'b0; if_f.wr_data = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(if_r.count), 32'd0);
    check("rst_empty", 32'(if_r.empty), 32'd1);
    check("rst_full",  32'(if_r.full), 32'd0);
    check("rst_af",    32'(if_r.almost_full), 32'd0);
    check("rst_ae",    32'(if_r.almost_empty), 32'd1);
    check("rst_ovf",   32'(if_r.overflow), 32'd0);
    check("rst_udf",   32'(if_r.underflow), 32'd0);
    check("rst_rdata", if_r.rd_data, 32'h0);
    check("rst_f_empty", 32'(if_f.empty), 32'd1);

    // Fill with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      if_r.wr_en = 1'b1;
      if_r.wr_data = 32'h10 + 32'(i);
      step();
      check("fill_count", 32'(if_r.count), 32'(i + 1));
      check("fill_af",    32'(if_r.almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_ae",    32'(if_r.almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
      check("fill_full",  32'(if_r.full), (i + 1 == 8) ? 32'd1 : 32'd0);
    end
    if_r.wr_data = 32'h99;
    step();
    if_r.wr_en = 1'b0;
    check("ovf_set",   32'(if_r.overflow), 32'd1);
    check("ovf_count", 32'(if_r.count), 32'd8);
    check("ovf_full",  32'(if_r.full), 32'd1);

    // Write + read on a full FIFO
    if_r.wr_en = 1'b1; if_r.rd_en = 1'b1; if_r.wr_data = 32'hAA;
    step();
    if_r.wr_en = 1'b0;
    check("fullrw_full",  32'(if_r.full), 32'd1);
    check("fullrw_count", 32'(if_r.count), 32'd8);
    check("fullrw_rdata", if_r.rd_data, 32'h10);
    for (int i = 0; i < 8; i++) begin
      step();
      check("drain_rdata", if_r.rd_data, (i < 7) ? 32'h11 + 32'(i) : 32'hAA);
    end
    if_r.rd_en = 1'b0;
    check("drain_empty", 32'(if_r.empty), 32'd1);
    check("ovf_sticky",  32'(if_r.overflow), 32'd1);
    if_r.err_clr = 1'b1;
    step();
    if_r.err_clr = 1'b0;
    check("ovf_clr", 32'(if_r.overflow), 32'd0);

    // Read + write on an empty FIFO
    if_r.rd_en = 1'b1; if_r.wr_en = 1'b1; if_r.wr_data = 32'h55;
    step();
    if_r.rd_en = 1'b0; if_r.wr_en = 1'b0;
    check("emptyrw_udf",   32'(if_r.underflow), 32'd1);
    check("emptyrw_count", 32'(if_r.count), 32'd1);
    check("emptyrw_rdata", if_r.rd_data, 32'hAA);
    if_r.err_clr = 1'b1;
    step();
    if_r.err_clr = 1'b0;
    check("udf_clr",   32'(if_r.underflow), 32'd0);
    check("clr_count", 32'(if_r.count), 32'd1);
    if_r.rd_en = 1'b1;
    step();
    check("pop55_rdata", if_r.rd_data, 32'h55);
    check("pop55_empty", 32'(if_r.empty), 32'd1);
    // Rejected read with err_clr in the same cycle: set wins
    if_r.err_clr = 1'b1;
    step();
    if_r.rd_en = 1'b0;
    check("setwins_udf", 32'(if_r.underflow), 32'd1);
    step();
    check("setwins_hold", 32'(if_r.underflow), 32'd0);
    if_r.err_clr = 1'b0;

    // FWFT head visibility and same-cycle pop
    if_f.wr_en = 1'b1; if_f.wr_data = 32'h33;
    step();
    if_f.wr_en = 1'b0;
    check("fwft_empty", 32'(if_f.empty), 32'd0);
    check("fwft_head",  if_f.rd_data, 32'h33);
    if_f.rd_en = 1'b1;
    step();
    if_f.rd_en = 1'b0;
    check("fwft_pop_empty", 32'(if_f.empty), 32'd1);
    if_f.wr_en = 1'b1; if_f.wr_data = 32'h44;
    step();
    if_f.wr_data = 32'h45;
    step();
    if_f.wr_en = 1'b0;
    check("fwft_head2", if_f.rd_data, 32'h44);
    if_f.rd_en = 1'b1;
    step();
    check("fwft_head3", if_f.rd_data, 32'h45);
    step();
    if_f.rd_en = 1'b0;
    check("fwft_drained", 32'(if_f.empty), 32'd1);

    // Pointer wrap: 20 write-then-read pairs
    for (int i = 0; i < 20; i++) begin
      if_r.wr_en = 1'b1; if_r.wr_data = 32'h100 + 32'(i);
      step();
      if_r.wr_en = 1'b0;
      check("wrap_count_w", 32'(if_r.count), 32'd1);
      if_r.rd_en = 1'b1;
      step();
      if_r.rd_en = 1'b0;
      check("wrap_rdata",   if_r.rd_data, 32'h100 + 32'(i));
      check("wrap_count_r", 32'(if_r.count), 32'd0);
    end

    // Reset with count == 5 and a sticky flag set; wr_en at the reset edge is ignored
    if_r.rd_en = 1'b1;
    step();
    if_r.rd_en = 1'b0;
    check("pre_rst_udf", 32'(if_r.underflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if_r.wr_en = 1'b1; if_r.wr_data = 32'h200 + 32'(i);
      step();
    end
    check("pre_rst_count", 32'(if_r.count), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_r.wr_en = 1'b0;
    check("mid_rst_count", 32'(if_r.count), 32'd0);
    check("mid_rst_empty", 32'(if_r.empty), 32'd1);
    check("mid_rst_ovf",   32'(if_r.overflow), 32'd0);
    check("mid_rst_udf",   32'(if_r.underflow), 32'd0);
    check("mid_rst_rdata", if_r.rd_data, 32'h0);
    check("mid_rst_ae",    32'(if_r.almost_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
